// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// returning tagged results on a valid/ready response channel.
// Optional macro ALU_RR_ARBITER_OPCHECK_EN: illegal opcodes bypass the ALU and respond with resp_err.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]   req_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [2:0]             alu_opcode,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [WIDTH-1:0]       resp_data,
    output logic                   resp_err,
    output logic [1:0]             state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and payload is held stable while valid && !ready.

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   next_ptr;
    logic            found;
    logic            grant;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [2:0]      win_op;

    assign state_dbg = state;

    // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
    always_comb begin
        int cand;
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = PW'(cand);
            end
        end
    end

    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PW'(k) == winner) begin
                win_a  = req_a[k*WIDTH +: WIDTH];
                win_b  = req_b[k*WIDTH +: WIDTH];
                win_op = req_op[k*3 +: 3];
            end
        end
    end

    assign grant    = (state == IDLE) && found;
    assign next_ptr = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + PW'(1);

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

`ifdef ALU_RR_ARBITER_OPCHECK_EN
    logic illegal_op;
    assign illegal_op = !(win_op inside {3'b001, 3'b010, 3'b011});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        rr_ptr  <= next_ptr;
                        resp_id <= IDW'(winner);
                        if (illegal_op) begin
                            // ALU operands deliberately left untouched for rejected ops
                            resp_data  <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            alu_a      <= win_a;
                            alu_b      <= win_b;
                            alu_opcode <= win_op;
                            resp_err   <= 1'b0;
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    resp_data  <= alu_result;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign resp_err = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        rr_ptr     <= next_ptr;
                        resp_id    <= IDW'(winner);
                        alu_a      <= win_a;
                        alu_b      <= win_b;
                        alu_opcode <= win_op;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_result;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ALU attached to the alu_* port.
// Expectations follow ALU_RR_ARBITER_OPCHECK_EN when it is defined for the build.
module tb_alu_rr_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [2:0]     alu_opcode;
  logic [W-1:0]   alu_result;
  logic           resp_valid;
  logic           resp_ready;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic [1:0]     state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  alu_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural shared ALU: unsigned compares, unknown opcodes give 0
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = {31'd0, alu_a > alu_b};
      3'b011: alu_result = {31'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end

  // driver tasks
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_op[i*3 +: 3] = op;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int exp_idx, output int gcyc);
    logic [N-1:0] exp_rr;
    int t;
    exp_rr = '0;
    exp_rr[exp_idx] = 1'b1;
    t = 0;
    #1;
    while (req_ready == '0 && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    vectors++;
    if (req_ready !== exp_rr) begin
      miscompares++;
      $display("FAIL grant: req_ready got %b expected %b", req_ready, exp_rr);
    end
    gcyc = cyc;
  endtask

  task automatic wait_resp(input int gcyc, input int exp_lat, input int exp_id,
                           input logic [W-1:0] exp_data, input logic exp_err);
    int t;
    t = 0;
    @(negedge clk);
    #1;
    while (!resp_valid && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL resp_timeout: resp_valid got %b expected 1", resp_valid);
    end
    vectors++;
    if (cyc - gcyc !== exp_lat) begin
      miscompares++;
      $display("FAIL latency: got %0d expected %0d", cyc - gcyc, exp_lat);
    end
    vectors++;
    if (resp_id !== IDW'(exp_id)) begin
      miscompares++;
      $display("FAIL resp_id: got %0d expected %0d", resp_id, exp_id);
    end
    vectors++;
    if (resp_data !== exp_data) begin
      miscompares++;
      $display("FAIL resp_data: got %h expected %h", resp_data, exp_data);
    end
    vectors++;
    if (resp_err !== exp_err) begin
      miscompares++;
      $display("FAIL resp_err: got %b expected %b", resp_err, exp_err);
    end
  endtask

  task automatic do_txn(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] exp_data);
    int g;
    @(negedge clk);
    set_req(idx, a, b, op);
    req_valid[idx] = 1'b1;
    wait_grant(idx, g);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    wait_resp(g, 2, idx, exp_data, 1'b0);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    resp_ready = 1'b1;
    #12;
    vectors++;
    if ({req_ready, resp_valid, resp_err, resp_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 0", {req_ready, resp_valid, resp_err, resp_id});
    end
    vectors++;
    if ({alu_a, alu_b, alu_opcode, resp_data} !== '0 || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_data: alu_a %h alu_b %h op %b data %h state %0d expected all 0",
               alu_a, alu_b, alu_opcode, resp_data, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_txn(0, 32'd10, 32'd3, 3'b001, 32'd7);
  endtask

  task automatic test_wrap();
    do_txn(2, 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF);
    do_txn(1, 32'd5, 32'd9, 3'b011, 32'd1);
    do_txn(1, 32'd5, 32'd9, 3'b010, 32'd0);
  endtask

  task automatic test_round_robin();
    int g;
    int exp;
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, W'(100 * (i + 1)), W'(i), 3'b001);
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      exp = k % N;
      wait_grant(exp, g);
      if (k == 4) begin
        @(posedge clk);
        #1;
        req_valid = '0;
      end
      wait_resp(g, 2, exp, W'(100 * (exp + 1) - exp), 1'b0);
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    int g;
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(1, 32'd20, 32'd5, 3'b001);
    set_req(2, 32'd7, 32'd2, 3'b010);
    req_valid = 4'b0010;
    wait_grant(1, g);
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    wait_resp(g, 2, 1, 32'd15, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'd15 || req_ready !== '0) begin
        miscompares++;
        $display("FAIL stall_hold: valid %b id %0d data %h ready %b expected 1/1/0000000f/0000",
                 resp_valid, resp_id, resp_data, req_ready);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL regrant_after_stall: req_ready got %b expected 0100", req_ready);
    end
    g = cyc;
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_resp(g, 2, 2, 32'd1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int g;
    @(negedge clk);
    set_req(3, 32'd55, 32'd44, 3'b001);
    req_valid = 4'b1000;
    wait_grant(3, g);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    vectors++;
    if (alu_a !== 32'd55 || state_dbg !== 2'd1) begin
      miscompares++;
      $display("FAIL exec_before_reset: alu_a %h state %0d expected 00000037/1", alu_a, state_dbg);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, resp_valid, resp_err, resp_id, alu_a, alu_b, alu_opcode, resp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: valid %b alu_a %h alu_b %h op %b expected all 0",
               resp_valid, alu_a, alu_b, alu_opcode);
    end
    for (int i = 0; i < N; i++) set_req(i, W'(1000 + i), 32'd1, 3'b001);
    req_valid = '1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(0, g);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_resp(g, 2, 0, 32'd999, 1'b0);
  endtask

  task automatic test_illegal_op();
    int g;
    logic [2:0] prev_op;
    @(negedge clk);
    prev_op = alu_opcode;
    set_req(3, 32'd9, 32'd4, 3'b111);
    req_valid = 4'b1000;
    wait_grant(3, g);
    @(posedge clk);
    #1;
    req_valid = '0;
`ifdef ALU_RR_ARBITER_OPCHECK_EN
    wait_resp(g, 1, 3, 32'd0, 1'b1);
    vectors++;
    if (alu_opcode !== prev_op) begin
      miscompares++;
      $display("FAIL illegal_alu_hold: alu_opcode got %b expected %b", alu_opcode, prev_op);
    end
`else
    wait_resp(g, 2, 3, 32'd0, 1'b0);
    vectors++;
    if (alu_opcode !== 3'b111 || prev_op === 3'b111) begin
      miscompares++;
      $display("FAIL illegal_passthru: alu_opcode got %b expected 111", alu_opcode);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    test_illegal_op();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational 32-bit ALU between NUM_REQ requesters.
- Each requester supplies two operands and a 3-bit opcode:
  - 001 = sub
  - 010 = gt
  - 011 = lt
- Block arbitrates round-robin, registers the granted operands, drives the ALU, captures its result and returns it on a single tagged response channel with valid/ready handshake.
- Sits between compute clients and the shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 32, operand/result width; must match the ALU.
- IDW, 2, response id width; must be ≥ clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  packed operand A; slice i belongs to requester i.
- req_b  input  NUM_REQ*WIDTH  packed operand B.
- req_op  input  NUM_REQ*3  packed opcodes.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_opcode  output  3  to ALU opcode.
- alu_result  input  WIDTH  from ALU result; combinational.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response accept.
- resp_id  output  IDW  index of requester that issued the response.
- resp_data  output  WIDTH  captured ALU result.
- resp_err  output  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_data = 0, resp_err = 0.
  - alu_a = 0, alu_b = 0, alu_opcode = 000.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally, same cycle; handshake completes that cycle.
  - On handshake: latch operands/opcode/id into op regs, rr_ptr <= (winner+1) mod NUM_REQ, go EXEC.
  - No valid: stay, req_ready = 0.
- EXEC:
  - alu_a/alu_b/alu_opcode driven from op regs; they are held from EXEC entry until the next grant.
  - Capture alu_result into resp_data, go RESP.
- RESP:
  - resp_valid = 1; resp_id/resp_data/resp_err stable until resp_ready.
  - On resp_valid & resp_ready, go IDLE.
  - req_ready = 0 in EXEC and RESP.
- Latency:
  - Grant at cycle N, resp_valid high at cycle N+2.
  - Minimum initiation interval 3 cycles (grant, exec, resp accepted).
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ grants.
  - Requester deasserting valid before grant is allowed; no grant issued to it.
- Simultaneous events:
  - All requesters valid with rr_ptr=0 gives grant order 0,1,2,3,0…
  - resp_ready held low stalls indefinitely; no new grant while in RESP.
- Widths: no arithmetic in the block; resp_data is alu_result bit-exact, including sub wrap-around (0 - 1 = 0xFFFF_FFFF).
- rr_ptr wrap: NUM_REQ-1 → 0.
- Reset mid-operation: in-flight request and pending response discarded; requesters must re-issue.

Optional Feature:
- Macro: ALU_RR_ARBITER_OPCHECK_EN.
- When defined:
  - Granted opcode not in {001, 010, 011} skips EXEC and goes IDLE → RESP directly.
  - resp_data = 0, resp_err = 1.
  - alu_* outputs unchanged for that transaction.
  - Latency for illegal opcodes is grant + 1.
- When undefined:
  - All opcodes pass through EXEC; ALU default yields 0.
  - resp_err tied 0.

Test Plan:
- Single request: req0 A=10, B=3, op=001 → req_ready[0] same cycle; resp_valid 2 cycles later; resp_id=0, resp_data=7, resp_err=0.
- Wrap: req2 A=0, B=1, op=001 → resp_data=0xFFFF_FFFF; then req1 A=5, B=9, op=011 → resp_data=1; req1 op=010 → resp_data=0.
- All four valid continuously, rr_ptr=0, resp_ready=1 → grants 0,1,2,3,0; resp_id sequence matches; each requester gets one grant per four.
- Backpressure: resp_ready=0 for 5 cycles during RESP → resp_valid/resp_id/resp_data held constant, all req_ready=0; after resp_ready=1, the next grant comes the following cycle.
- Reset: rst_n low asserted while in EXEC → all outputs 0 immediately, next post-reset grant to requester 0 when all are valid.
- Opcode check: req3 op=111 → with ALU_RR_ARBITER_OPCHECK_EN, resp 1 cycle after grant, resp_err=1, resp_data=0; without the macro, resp 2 cycles after grant, resp_err=0, resp_data=0.
